fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect draining and hazard hold buffer.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        data_hazard,
    input  logic        control_hazard,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    output logic        fetch_misaligned
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        started_q;
    logic [31:0] inst_d, pc_out_d;
    logic        valid_d;

    logic        accept;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] eff_target;
    logic        target_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    assign fetch_misaligned = trap_q;
    assign eff_target       = redirect_target;
    assign target_bad       = (redirect_target[1:0] != 2'b00);
`else
    assign fetch_misaligned = 1'b0;
    assign eff_target       = redirect_target & 32'hFFFF_FFFC;
    assign target_bad       = 1'b0;
`endif

    // started_q keeps imem_req low until the first edge after reset release.
    assign imem_req        = started_q && (state_q != S_HOLD) && !fetch_misaligned;
    assign imem_addr       = pc_q;
    assign accept          = imem_req && imem_ready;
    assign redirect        = jump_taken || pend_valid_q;
    assign redirect_target = jump_taken ? jump_target : pend_target_q;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_buf_d    = hold_buf_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        inst_d        = inst_out;
        pc_out_d      = pc_out;
        valid_d       = inst_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d        = trap_q;
`endif

        if (fetch_misaligned) begin
            state_d = state_q;
        end else if (stall) begin
            // Pipeline frozen; still capture a returning word so it is not lost.
            if (jump_taken) begin
                pend_valid_d  = 1'b1;
                pend_target_d = jump_target;
            end
            if (accept) begin
                if (state_q == S_DRAIN) begin
                    state_d = S_FETCH;
                end else begin
                    hold_buf_d = imem_rdata;
                    state_d    = S_HOLD;
                end
            end
        end else if (redirect) begin
            pend_valid_d = 1'b0;
            inst_d       = NOP_INST;
            valid_d      = 1'b0;
            if (target_bad) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_d = 1'b1;
`endif
            end else begin
                pc_d       = eff_target;
                hold_buf_d = '0;
                state_d    = (imem_req && !imem_ready) ? S_DRAIN : S_FETCH;
            end
        end else if (control_hazard) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            if (state_q == S_DRAIN && accept) begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (accept) begin
                        if (data_hazard) begin
                            hold_buf_d = imem_rdata;
                            state_d    = S_HOLD;
                        end else begin
                            inst_d   = imem_rdata;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                            pc_d     = pc_q + 32'd4;
                        end
                    end else if (!data_hazard) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!data_hazard) begin
                        inst_d   = hold_buf_q;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if (accept) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            hold_buf_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            started_q     <= 1'b0;
            inst_out      <= NOP_INST;
            pc_out        <= RESET_PC;
            inst_valid    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_buf_q    <= hold_buf_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            started_q     <= 1'b1;
            inst_out      <= inst_d;
            pc_out        <= pc_out_d;
            inst_valid    <= valid_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset/misalign sequences,
// and randomized traffic against a behavioural reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, data_hazard = 1'b0, control_hazard = 1'b0, jump_taken = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr, inst_out, pc_out;
    logic        inst_valid, fetch_misaligned;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .data_hazard      (data_hazard),
        .control_hazard   (control_hazard),
        .jump_taken       (jump_taken),
        .jump_target      (jump_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .inst_out         (inst_out),
        .pc_out           (pc_out),
        .inst_valid       (inst_valid),
        .fetch_misaligned (fetch_misaligned)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_valid);
        check({tag, ".imem_req"},   {31'd0, imem_req},   {31'd0, e_req});
        check({tag, ".imem_addr"},  imem_addr,           e_addr);
        check({tag, ".inst_out"},   inst_out,            e_inst);
        check({tag, ".pc_out"},     pc_out,              e_pc);
        check({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
    endtask

    task automatic drive(input logic s, input logic d, input logic c, input logic j,
                         input logic [31:0] t, input logic r, input logic [31:0] rd);
        stall = s; data_hazard = d; control_hazard = c; jump_taken = j;
        jump_target = t; imem_ready = r; imem_rdata = rd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        s, d, c, j;
        logic [31:0] t;
        logic        r;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr, e_inst, e_pc;
        logic        e_valid;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    // Reference model: buffer-occupied / drop-next flags plus architectural registers.
    logic [31:0] m_pc, m_buf, m_pt, m_inst, m_pco;
    logic        m_hb, m_drop, m_pv, m_started, m_valid, m_mis;

    function automatic logic m_req();
        return m_started && !m_hb && !m_mis;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_buf = '0; m_pt = '0; m_inst = NOP; m_pco = 32'h0;
        m_hb = 0; m_drop = 0; m_pv = 0; m_started = 0; m_valid = 0; m_mis = 0;
    endtask

    task automatic present(input logic [31:0] w);
        m_inst = w; m_pco = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    endtask

    task automatic bubble();
        m_inst = NOP; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic d, input logic c, input logic j,
                              input logic [31:0] t, input logic r, input logic [31:0] rd);
        logic        req, acc;
        logic [31:0] tg;
        req = m_req();
        acc = req && r;
        m_started = 1'b1;
        if (m_mis) begin
            m_started = 1'b1;
        end else if (s) begin
            if (j) begin m_pv = 1'b1; m_pt = t; end
            if (acc) begin
                if (m_drop) m_drop = 1'b0;
                else begin m_hb = 1'b1; m_buf = rd; end
            end
        end else if (j || m_pv) begin
            tg = j ? t : m_pt;
            m_pv = 1'b0;
            bubble();
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tg[1:0] != 2'b00) m_mis = 1'b1;
            else begin
                m_pc = {tg[31:2], 2'b00}; m_hb = 1'b0; m_drop = req && !r;
            end
`else
            m_pc = {tg[31:2], 2'b00}; m_hb = 1'b0; m_drop = req && !r;
`endif
        end else if (c) begin
            bubble();
            if (m_drop && acc) m_drop = 1'b0;
        end else if (m_drop) begin
            bubble();
            if (acc) m_drop = 1'b0;
        end else if (m_hb) begin
            if (!d) begin present(m_buf); m_hb = 1'b0; end
        end else if (acc) begin
            if (d) begin m_hb = 1'b1; m_buf = rd; end
            else present(rd);
        end else if (!d) begin
            bubble();
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic        s, d, c, j, r;
        logic [31:0] t, rd;

        //          s  d  c  j  target        r  rdata          req addr          inst           pc            v
        vecs[0]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0000_0000, NOP,           32'h0000_0000, 0};
        vecs[1]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0011, 1, 32'h0000_0004, 32'h0000_0011, 32'h0000_0000, 1};
        vecs[2]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0022, 1, 32'h0000_0008, 32'h0000_0022, 32'h0000_0004, 1};
        vecs[3]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0033, 1, 32'h0000_000C, 32'h0000_0033, 32'h0000_0008, 1};
        vecs[4]  = '{0, 1, 0, 0, 32'h0,        1, 32'hAAAA_0001, 0, 32'h0000_000C, 32'h0000_0033, 32'h0000_0008, 1};
        vecs[5]  = '{0, 1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0000_000C, 32'h0000_0033, 32'h0000_0008, 1};
        vecs[6]  = '{0, 1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0000_000C, 32'h0000_0033, 32'h0000_0008, 1};
        vecs[7]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0000_0010, 32'hAAAA_0001, 32'h0000_000C, 1};
        vecs[8]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0000_0010, NOP,           32'h0000_000C, 0};
        vecs[9]  = '{0, 0, 0, 1, 32'h100,      0, 32'h0,         1, 32'h0000_0100, NOP,           32'h0000_000C, 0};
        vecs[10] = '{0, 0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h0000_0100, NOP,           32'h0000_000C, 0};
        vecs[11] = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0044, 1, 32'h0000_0104, 32'h0000_0044, 32'h0000_0100, 1};
        vecs[12] = '{1, 0, 0, 1, 32'h200,      0, 32'h0,         1, 32'h0000_0104, 32'h0000_0044, 32'h0000_0100, 1};
        vecs[13] = '{1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0000_0104, 32'h0000_0044, 32'h0000_0100, 1};
        vecs[14] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0000_0200, NOP,           32'h0000_0100, 0};
        vecs[15] = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0055, 1, 32'h0000_0200, NOP,           32'h0000_0100, 0};
        vecs[16] = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0066, 1, 32'h0000_0204, 32'h0000_0066, 32'h0000_0200, 1};
        vecs[17] = '{0, 0, 1, 0, 32'h0,        1, 32'h0000_0077, 1, 32'h0000_0204, NOP,           32'h0000_0200, 0};
        vecs[18] = '{0, 0, 1, 0, 32'h0,        1, 32'h0000_0077, 1, 32'h0000_0204, NOP,           32'h0000_0200, 0};
        vecs[19] = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0077, 1, 32'h0000_0208, 32'h0000_0077, 32'h0000_0204, 1};
        vecs[20] = '{0, 1, 0, 0, 32'h0,        1, 32'h0000_0088, 0, 32'h0000_0208, 32'h0000_0077, 32'h0000_0204, 1};

        // Reset state while rst is held.
        @(negedge clk);
        check_outs("reset", 0, 32'h0, NOP, 32'h0, 0);
        check("reset.misaligned", {31'd0, fetch_misaligned}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].s, vecs[i].d, vecs[i].c, vecs[i].j, vecs[i].t, vecs[i].r, vecs[i].rd);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_valid);
        end

        // Asynchronous reset while a word sits in the hold buffer.
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_outs("async_rst", 0, 32'h0, NOP, 32'h0, 0);
        check("async_rst.misaligned", {31'd0, fetch_misaligned}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 1, 32'h0000_0099);
        step();
        check_outs("post_rst0", 1, 32'h0, NOP, 32'h0, 0);
        step();
        check_outs("post_rst1", 1, 32'h4, 32'h0000_0099, 32'h0, 1);

        // Misaligned redirect.
        reset_pulse();
        step();
        drive(0, 0, 0, 1, 32'h102, 0, 32'h0);
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign.flag", {31'd0, fetch_misaligned}, 32'h1);
        check("misalign.req",  {31'd0, imem_req},         32'h0);
        check("misalign.addr", imem_addr,                 32'h0);
        drive(0, 0, 0, 1, 32'h300, 1, 32'h1);
        step();
        check("misalign.sticky", {31'd0, fetch_misaligned}, 32'h1);
        check("misalign.req2",   {31'd0, imem_req},         32'h0);
`else
        check("misalign.flag", {31'd0, fetch_misaligned}, 32'h0);
        check("misalign.req",  {31'd0, imem_req},         32'h1);
        check("misalign.addr", imem_addr,                 32'h100);
`endif

        // Randomized traffic against the reference model.
        reset_pulse();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            s  = ($urandom_range(0, 5) == 0);
            d  = ($urandom_range(0, 4) == 0);
            c  = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 15) == 0);
            t  = $urandom;
            t[1:0] = 2'b00;
            r  = ($urandom_range(0, 1) == 1);
            rd = $urandom;
            drive(s, d, c, j, t, r, rd);
            model_step(s, d, c, j, t, r, rd);
            step();
            check_outs($sformatf("rnd%0d", k), m_req(), m_pc, m_inst, m_pco, m_valid);
            check($sformatf("rnd%0d.misaligned", k), {31'd0, fetch_misaligned}, {31'd0, m_mis});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
